fifo_burst_arbiter: RTL and testbench
=====================================

# fifo_burst_arbiter

Round-robin burst arbiter that shares one downstream stream among `Nc` per-slot FIFO read ports, typically the `out` sides of per-channel async FIFOs. A channel is granted only when its reported occupancy is at least `MIN_BURST` words. The granted channel's words are forwarded as one framed burst: an optional header, then up to `BURST_MAX` data words with `out_last` on the final word. The block runs entirely in the FIFO read clock domain.

## Interface
- `Nc`, 4: number of requesting channels (2..16).
- `Nb`, 32: data width; must be ≥ 16.
- `M`, 2: FIFO address bits; occupancy inputs are `M+1` bits wide.
- `BURST_MAX`, 16: maximum data words per burst (1..255).
- `MIN_BURST`, 1: minimum occupancy for a channel to be eligible (1..`BURST_MAX`).

Ports:
- `clk` in 1: clock, the FIFO read clock.
- `reset` in 1: reset, synchronous, active-high.
- `in_valid` in `Nc`: per-channel word available.
- `in_ready` out `Nc`: per-channel pop. At most one bit is high at a time.
- `in_data` in `Nc*Nb`: channel `i` occupies `[i*Nb +: Nb]`.
- `in_count` in `Nc*(M+1)`: per-channel occupancy, treated as a lower bound.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `Nb`: downstream stream.
- `out_last` out 1: final data word of the burst.
- `busy` out 1: state is not IDLE.
- `grant_id` out `$clog2(Nc)`: currently or last granted channel.

## Operation
- States: IDLE, HEADER, BURST.
- IDLE, eligibility:
  - Channel `i` is eligible when `in_count[i] >= MIN_BURST`.
  - The picker searches from `ptr+1` upward, wrapping modulo `Nc`, and takes the first eligible channel.
- IDLE, on a pick:
  - Register `grant_id`.
  - Set `len = min(in_count, BURST_MAX)`, sampled in that cycle.
  - Set `ptr <= grant_id`.
  - Go to HEADER (or BURST when the header is compiled out).
- IDLE with no eligible channel: remain in IDLE.
- HEADER:
  - `out_valid = 1`.
  - `out_data = {zeros, 8-bit channel id, 8-bit len}`.
  - Go to BURST on `out_ready`.
  - `in_ready` is all zero.
- BURST:
  - `out_valid = in_valid[g]`, `out_data = in_data[g]`, `in_ready[g] = out_ready`. All other `in_ready` bits are 0.
  - A word transfers on `in_valid[g] && out_ready`; each transfer decrements `remaining`.
  - `out_last = (remaining == 1)`.
  - The transfer of the last word returns the state to IDLE.
- Stall mid-burst: if `in_valid[g]` drops, the block holds BURST and the grant, with `out_valid = 0`. There is no timeout.
- Counts are lower bounds (synchronized pointers lag), so `len` words always arrive eventually.
- Count changes after the IDLE sample do not alter `len`.
- Arithmetic:
  - `len` and `remaining` are 8 bits.
  - `in_count` is zero-extended before comparison.
  - No wrap is possible because `BURST_MAX ≤ 255`.
- Fairness: the channel just served has lowest priority at the next pick. A channel is never granted twice in a row while another channel is eligible.

## Timing
- Reset values:
  - state IDLE; `ptr = Nc-1`, so channel 0 is preferred first.
  - `grant_id = 0`, `len = 0`, `remaining = 0`.
  - `out_valid = 0`, `out_last = 0`, `out_data = 0`, `in_ready = 0`, `busy = 0`.
- Reset mid-burst: the burst is abandoned immediately. Downstream must discard the partial frame. Unpopped words remain in their FIFOs.
- Latency from eligibility to header `out_valid`: 1 cycle (IDLE decision is registered).
- Header held with `out_ready = 0`: `out_data` is stable until accepted.
- BURST to IDLE to the next header: 1 IDLE cycle minimum between bursts.
- Throughput within a burst: 1 word per cycle when `in_valid` and `out_ready` are both high.

## Configuration
- `FIFO_ARB_HEADER_EN` defined:
  - HEADER state and header word are present.
  - A burst of `len` words occupies `len+1` output transfers.
- `FIFO_ARB_HEADER_EN` undefined:
  - HEADER state is removed; IDLE goes directly to BURST.
  - Framing is carried only by `out_last` and `grant_id`, which stays valid for the whole burst.

## Structure
- Package `fifo_arb_pkg` holds:
  - state enum `arb_state_t`;
  - header field constants: `HDR_ID_LSB = 8`, `HDR_LEN_LSB = 0`, field width 8.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `Nc`-bit eligible vector and `ptr`.
  - Outputs: `found` and `idx`.
  - It is reused by other slot arbiters.

## Test plan
- Reset, then `in_count[2] = 3`, others 0, `out_ready = 1`. Required: header `0x0000_0203`, 3 words from channel 2, `out_last` on word 3, then IDLE with `busy = 0`.
- All channels with `count = 4`, repeated. Required: grant order 0, 1, 2, 3, 0, each burst of 4 words.
- `in_count[1] = 7` with `BURST_MAX = 16`, then count rises to 20 mid-burst. Required: `len = 7`. Next pick from the same lone channel gives `len = 16`.
- `out_ready` toggled 1/0 during the header and the burst. Required: data stable while stalled, no lost or duplicated words, `in_ready` follows `out_ready`.
- `in_valid` drops for 5 cycles mid-burst. Required: `out_valid = 0`, burst resumes, `remaining` correct. Then assert `reset` mid-burst: next cycle state is IDLE and all outputs are at reset values.
- With `FIFO_ARB_HEADER_EN` undefined: channel 0 with `count = 2` yields exactly 2 output transfers, the second with `out_last`.

Source files
------------

// File: rtl/fifo_burst_arbiter_pkg.sv
// Shared types and header field layout for the FIFO burst arbiter family.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BURST  = 2'd2
  } arb_state_t;

  localparam int HDR_ID_LSB  = 8;
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_FIELD_W = 8;

  function automatic logic [7:0] clamp_len(input logic [31:0] cnt, input logic [31:0] cap);
    return (cnt > cap) ? cap[7:0] : cnt[7:0];
  endfunction

endpackage

// File: rtl/fifo_burst_arbiter_if.sv
// Per-channel FIFO read ports plus the shared downstream stream; master is the arbiter side.
interface fifo_burst_arbiter_if #(
  parameter int Nc = 4,
  parameter int Nb = 32,
  parameter int M  = 2
);
  logic [Nc-1:0]         in_valid;
  logic [Nc-1:0]         in_ready;
  logic [Nc*Nb-1:0]      in_data;
  logic [Nc*(M+1)-1:0]   in_count;
  logic                  out_valid;
  logic                  out_ready;
  logic [Nb-1:0]         out_data;
  logic                  out_last;
  logic                  busy;
  logic [$clog2(Nc)-1:0] grant_id;

  modport master (
    input  in_valid, in_data, in_count, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, grant_id
  );

  modport slave (
    output in_valid, in_data, in_count, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, grant_id
  );
endinterface

// File: rtl/fifo_burst_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or after ptr+1, wrapping.
module rr_pick #(
  parameter int Nc = 4
) (
  input  logic [Nc-1:0]         eligible,
  input  logic [$clog2(Nc)-1:0] ptr,
  output logic                  found,
  output logic [$clog2(Nc)-1:0] idx
);
  localparam int IW = $clog2(Nc);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // k = Nc lands back on ptr itself, so the last-served channel is tried last
    for (int k = 1; k <= Nc; k++) begin
      cand = IW'((int'(ptr) + k) % Nc);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/fifo_burst_arbiter.sv
// Round-robin burst arbiter over Nc FIFO read ports; header valid 1 cycle after eligibility, 1 word/cycle in burst.
// Stalls on out_ready (header and data held) or on in_valid of the granted channel; header present only with FIFO_ARB_HEADER_EN.
module fifo_burst_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int Nc        = 4,
  parameter int Nb        = 32,
  parameter int M         = 2,
  parameter int BURST_MAX = 16,
  parameter int MIN_BURST = 1
) (
  input logic                  clk,
  input logic                  reset,
  fifo_burst_arbiter_if.master bus
);
  localparam int IW = $clog2(Nc);
  localparam int CW = M + 1;

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic [7:0]    remaining;
  logic [7:0]    len_pick;
  logic [Nc-1:0] eligible;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [CW-1:0] pick_cnt;
  logic          xfer;

  always_comb begin
    for (int i = 0; i < Nc; i++) begin
      eligible[i] = 32'(bus.in_count[i*CW +: CW]) >= 32'(MIN_BURST);
    end
  end

  rr_pick #(.Nc(Nc)) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign pick_cnt = bus.in_count[int'(pick_idx)*CW +: CW];
  assign len_pick = clamp_len(32'(pick_cnt), 32'(BURST_MAX));
  assign xfer     = bus.in_valid[grant] && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= IW'(Nc - 1);
      grant     <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) begin
        grant     <= pick_idx;
        ptr       <= pick_idx;
        remaining <= len_pick;
      end else if (state == BURST && xfer) begin
        remaining <= remaining - 8'd1;
      end
    end
  end

`ifdef FIFO_ARB_HEADER_EN
  // Burst length is only observable through the header word.
  logic [7:0] len;

  always_ff @(posedge clk) begin
    if (reset) begin
      len <= '0;
    end else if (state == IDLE && pick_found) begin
      len <= len_pick;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.in_ready  = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
`ifdef FIFO_ARB_HEADER_EN
          state_nxt = HEADER;
`else
          state_nxt = BURST;
`endif
        end
      end
`ifdef FIFO_ARB_HEADER_EN
      HEADER: begin
        bus.out_valid = 1'b1;
        bus.out_data[HDR_ID_LSB +: HDR_FIELD_W]  = HDR_FIELD_W'(grant);
        bus.out_data[HDR_LEN_LSB +: HDR_FIELD_W] = len;
        if (bus.out_ready) state_nxt = BURST;
      end
`endif
      BURST: begin
        bus.out_valid       = bus.in_valid[grant];
        bus.out_data        = bus.in_data[int'(grant)*Nb +: Nb];
        bus.out_last        = (remaining == 8'd1);
        bus.in_ready[grant] = bus.out_ready;
        if (xfer && remaining == 8'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.grant_id = grant;
endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Scoreboard bench for fifo_burst_arbiter; expects a header word per burst when FIFO_ARB_HEADER_EN is defined.
module tb_fifo_burst_arbiter;
  localparam int NC   = 4;
  localparam int NB   = 32;
  localparam int M    = 4;
  localparam int CW   = M + 1;
  localparam int BMAX = 16;
`ifdef FIFO_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  gid;
  } exp_t;

  typedef struct {
    int ch;
    int words;
    int first_len;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_burst_arbiter_if #(.Nc(NC), .Nb(NB), .M(M)) bus();

  fifo_burst_arbiter #(
    .Nc(NC), .Nb(NB), .M(M), .BURST_MAX(BMAX), .MIN_BURST(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          pushed[NC];
  int          popped[NC];
  int          exp_seq[NC];
  bit          stall[NC];
  int          cnt_cap   = 31;
  int          rdy_mode  = 0;
  int          n_cmp     = 0;
  int          n_bad     = 0;
  int          xfers     = 0;
  logic        last_ov, last_busy;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;

  function automatic logic [31:0] mkword(input int c, input int n);
    return 32'hA500_0000 | (32'(c) << 16) | (32'(n) & 32'h0000_FFFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic expect_burst(input int c, input int len);
    exp_t e;
    if (HDR == 1) begin
      e.data = (32'(c) << 8) | 32'(len);
      e.last = 1'b0;
      e.gid  = 2'(c);
      sb.push_back(e);
    end
    for (int k = 0; k < len; k++) begin
      e.data = mkword(c, exp_seq[c]);
      e.last = (k == len - 1);
      e.gid  = 2'(c);
      sb.push_back(e);
      exp_seq[c]++;
    end
  endtask

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      int avail;
      int cnt;
      avail = pushed[c] - popped[c];
      bus.in_valid[c] = (avail > 0) && !stall[c];
      bus.in_data[c*NB +: NB] = (avail > 0) ? mkword(c, popped[c]) : '0;
      cnt = (avail < cnt_cap) ? avail : cnt_cap;
      if (cnt > 31) cnt = 31;
      bus.in_count[c*CW +: CW] = CW'(cnt);
    end
    case (rdy_mode)
      1:       bus.out_ready = !bus.out_ready;
      2:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'b1;
    endcase
  endtask

  task automatic monitor();
    exp_t       e;
    logic [3:0] exp_rdy;
    if (prev_stall && bus.out_valid) chk("stall_stable", bus.out_data, prev_data);
    chk("in_ready_gated", 32'(bus.in_ready & ~{NC{bus.out_ready}}), 32'd0);
    if (bus.in_ready != '0) begin
      exp_rdy = (sb.size() > 0) ? (4'b0001 << sb[0].gid) : 4'b0000;
      chk("in_ready_grant", 32'(bus.in_ready), 32'(exp_rdy));
    end
    if (bus.out_valid && bus.out_ready) begin
      xfers++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_xfer: got data=%h last=%b gid=%0d, expected no transfer",
                 bus.out_data, bus.out_last, bus.grant_id);
      end else begin
        e = sb.pop_front();
        if (bus.out_data !== e.data || bus.out_last !== e.last || bus.grant_id !== e.gid) begin
          n_bad++;
          $display("FAIL xfer: got data=%h last=%b gid=%0d, expected data=%h last=%b gid=%0d",
                   bus.out_data, bus.out_last, bus.grant_id, e.data, e.last, e.gid);
        end
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    last_ov    = bus.out_valid;
    last_busy  = bus.busy;
  endtask

  task automatic step();
    logic [NC-1:0] pop;
    @(negedge clk);
    monitor();
    pop = bus.in_ready & bus.in_valid;
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) if (pop[c]) popped[c]++;
    drive();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_xfers(input int target);
    int n;
    n = 0;
    while (xfers < target && n < 200) begin
      step();
      n++;
    end
    chk("mid_burst_reached", 32'(xfers >= target), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   t0, rem, nb, l;

    vt[0] = '{2, 3, 3};
    vt[1] = '{0, 2, 2};
    vt[2] = '{3, 16, 16};
    vt[3] = '{1, 20, 16};
    vt[4] = '{0, 1, 1};

    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive();

    // Fairness: all channels eligible with capped count, order must rotate from channel 0
    cnt_cap = 4;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++) expect_burst(c, 4);
    for (int c = 0; c < NC; c++) pushed[c] += 8;
    drive();
    wait_drain("fair", 400);
    cnt_cap = 31;
    drive();

    // Lone-channel bursts, including length clamp and pick latency
    for (int i = 0; i < 5; i++) begin
      t0  = xfers;
      rem = vt[i].words;
      expect_burst(vt[i].ch, vt[i].first_len);
      nb  = 1;
      rem -= vt[i].first_len;
      while (rem > 0) begin
        l = (rem > BMAX) ? BMAX : rem;
        expect_burst(vt[i].ch, l);
        nb++;
        rem -= l;
      end
      pushed[vt[i].ch] += vt[i].words;
      drive();
      @(negedge clk);
      chk("pick_cycle_idle", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      step();
      chk("first_out_valid", 32'(last_ov), 32'd1);
      wait_drain("vec", 300);
      chk("vec_xfers", 32'(xfers - t0), 32'(vt[i].words + nb * HDR));
    end

    // Count rises mid-burst: len stays at the sampled 7, next burst takes 16
    t0 = xfers;
    expect_burst(1, 7);
    pushed[1] += 7;
    drive();
    wait_xfers(t0 + 3);
    expect_burst(1, 16);
    pushed[1] += 16;
    drive();
    wait_drain("count_rise", 300);

    // out_ready toggling during header and burst
    rdy_mode = 1;
    expect_burst(0, 6);
    pushed[0] += 6;
    drive();
    wait_drain("rdy_toggle", 300);
    rdy_mode = 0;
    drive();

    // in_valid drop for 5 cycles mid-burst
    t0 = xfers;
    expect_burst(2, 10);
    pushed[2] += 10;
    drive();
    wait_xfers(t0 + 4);
    stall[2] = 1'b1;
    drive();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_out_valid", 32'(last_ov), 32'd0);
      chk("stall_busy", 32'(last_busy), 32'd1);
    end
    stall[2] = 1'b0;
    drive();
    wait_drain("in_stall", 300);

    // Reset mid-burst abandons the frame; leftover words are re-served afterwards
    t0 = xfers;
    expect_burst(3, 8);
    pushed[3] += 8;
    drive();
    wait_xfers(t0 + 3);
    rdy_mode = 2;
    reset    = 1'b1;
    drive();
    step();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_last", 32'(bus.out_last), 32'd0);
    chk("mid_rst_out_data", bus.out_data, 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    prev_stall = 1'b0;
    sb.delete();
    exp_seq[3] = popped[3];
    rdy_mode   = 0;
    expect_burst(3, pushed[3] - popped[3]);
    drive();
    wait_drain("after_rst", 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
